// File: rtl/fifo_param.sv
// Single-clock synchronous FIFO with registered read data, level flags,
// sticky overflow/underflow indicators and a synchronous flush.
module fifo_param #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       clear_n,
  input  logic                       flush,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       rd,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_out_valid,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_nxt_c;
  logic             rd_ok_c;
  logic             wr_ok_c;

  // Level flags decode directly from the registered word count
  assign empty        = (count == '0);
  assign full         = (count == CNT_W'(DEPTH));
  assign almost_full  = (count >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count <= CNT_W'(AE_LEVEL));

  // A full FIFO still takes a write when a read frees a slot on the same edge
  assign rd_ok_c = rd & ~empty;
  assign wr_ok_c = wr & (~full | rd_ok_c);

  always_comb begin
    count_nxt_c = count;
    unique case ({wr_ok_c, rd_ok_c})
      2'b10:   count_nxt_c = count + CNT_W'(1);
      2'b01:   count_nxt_c = count - CNT_W'(1);
      default: count_nxt_c = count;
    endcase
  end

  // Storage is not reset; stale words are never reachable past count
  always_ff @(posedge clk) begin
    if (wr_ok_c && !flush) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
    end else if (flush) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      data_out_valid <= 1'b0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      count          <= count_nxt_c;
      data_out_valid <= rd_ok_c;
      if (wr_ok_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_ok_c) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PTR_W'(1);
      end
      if (rd && empty) begin
        underflow <= 1'b1;
      end
      if (wr && !wr_ok_c) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param (DEPTH=4) checked against a queue-based model
// plus hand-computed expectations for the key scenarios.
module tb_fifo_param;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned AF = 3;
  localparam int unsigned AE = 1;

  logic         clk = 1'b0;
  logic         clear_n;
  logic         flush;
  logic         wr;
  logic         rd;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;
  logic         data_out_valid;
  logic         empty;
  logic         full;
  logic         almost_full;
  logic         almost_empty;
  logic [2:0]   count;
  logic         overflow;
  logic         underflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] q [$];
  logic [W-1:0] m_dout;
  logic         m_dv;
  logic         m_ovf;
  logic         m_unf;

  fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk            (clk),
    .clear_n        (clear_n),
    .flush          (flush),
    .wr             (wr),
    .data_in        (data_in),
    .rd             (rd),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .empty          (empty),
    .full           (full),
    .almost_full    (almost_full),
    .almost_empty   (almost_empty),
    .count          (count),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_dv   = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // Behavioural FIFO: what one edge does given the inputs held across it
  task automatic model_edge(input logic f, input logic w, input logic r, input logic [W-1:0] d);
    bit rd_ok;
    bit wr_ok;
    if (f) begin
      q.delete();
      m_dv  = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      return;
    end
    rd_ok = r && (q.size() > 0);
    wr_ok = w && ((q.size() < D) || rd_ok);
    if (r && q.size() == 0) m_unf = 1'b1;
    if (w && !wr_ok)        m_ovf = 1'b1;
    if (rd_ok) begin
      m_dout = q.pop_front();
      m_dv   = 1'b1;
    end else begin
      m_dv = 1'b0;
    end
    if (wr_ok) q.push_back(d);
  endtask

  task automatic compare_all();
    int n;
    n = q.size();
    chk("count",        32'(count),          32'(n));
    chk("empty",        32'(empty),          32'(n == 0));
    chk("full",         32'(full),           32'(n == D));
    chk("almost_full",  32'(almost_full),    32'(n >= AF));
    chk("almost_empty", 32'(almost_empty),   32'(n <= AE));
    chk("data_out_valid", 32'(data_out_valid), 32'(m_dv));
    chk("data_out",     32'(data_out),       32'(m_dout));
    chk("overflow",     32'(overflow),       32'(m_ovf));
    chk("underflow",    32'(underflow),      32'(m_unf));
  endtask

  // Inputs change on the falling edge; outputs are compared on the next falling edge
  task automatic step(input logic f, input logic w, input logic r, input logic [W-1:0] d);
    flush   = f;
    wr      = w;
    rd      = r;
    data_in = d;
    @(posedge clk);
    model_edge(f, w, r, d);
    @(negedge clk);
    compare_all();
    flush   = 1'b0;
    wr      = 1'b0;
    rd      = 1'b0;
  endtask

  initial begin
    clear_n = 1'b0;
    flush   = 1'b0;
    wr      = 1'b0;
    rd      = 1'b0;
    data_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_ae",    32'(almost_empty), 32'd1);
    clear_n = 1'b1;

    // Simultaneous write/read on empty: write only, underflow
    step(1'b0, 1'b1, 1'b1, 8'h01);
    chk("e_wr_rd_count", 32'(count), 32'd1);
    chk("e_wr_rd_dv",    32'(data_out_valid), 32'd0);
    chk("e_wr_rd_unf",   32'(underflow), 32'd1);
    chk("e_wr_rd_empty", 32'(empty), 32'd0);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("first_rd_data", 32'(data_out), 32'h01);
    chk("first_rd_dv",   32'(data_out_valid), 32'd1);
    chk("first_rd_cnt",  32'(count), 32'd0);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("flush_unf", 32'(underflow), 32'd0);

    // Fill to full, then overflow
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
      if (i == 2) chk("af_at_3", 32'(almost_full), 32'd1);
    end
    chk("full_at_4", 32'(full), 32'd1);
    step(1'b0, 1'b1, 1'b0, 8'h14);
    chk("ovf_set",   32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk("drain_data", 32'(data_out), 32'(8'h10 + i));
      chk("drain_dv",   32'(data_out_valid), 32'd1);
    end

    // Full with write+read: oldest out, new word in, pointers wrap
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
    step(1'b0, 1'b1, 1'b1, 8'h20);
    chk("full_wr_rd_data",  32'(data_out), 32'h10);
    chk("full_wr_rd_count", 32'(count), 32'd4);
    begin
      logic [W-1:0] exp_tail [4];
      exp_tail = '{8'h11, 8'h12, 8'h13, 8'h20};
      for (int i = 0; i < 4; i++) begin
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("wrap_data", 32'(data_out), 32'(exp_tail[i]));
      end
    end
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("empty_rd_dv",   32'(data_out_valid), 32'd0);
    chk("empty_rd_hold", 32'(data_out), 32'h20);

    // Flush wins over a concurrent write and read
    step(1'b0, 1'b1, 1'b0, 8'h41);
    step(1'b0, 1'b1, 1'b0, 8'h42);
    chk("pre_flush_cnt", 32'(count), 32'd2);
    chk("pre_flush_ovf", 32'(overflow), 32'd1);
    step(1'b1, 1'b1, 1'b1, 8'h77);
    chk("flush_cnt",   32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_ovf",   32'(overflow), 32'd0);
    chk("flush_dv",    32'(data_out_valid), 32'd0);
    chk("flush_dout",  32'(data_out), 32'h20);

    // Pseudo-random traffic against the model
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 8'($urandom));
    end
    step(1'b1, 1'b0, 1'b0, 8'h00);

    // Asynchronous reset between edges with words stored
    step(1'b0, 1'b1, 1'b0, 8'h31);
    step(1'b0, 1'b1, 1'b0, 8'h32);
    step(1'b0, 1'b1, 1'b1, 8'h33);
    step(1'b0, 1'b1, 1'b0, 8'h34);
    chk("pre_rst_cnt", 32'(count), 32'd3);
    @(posedge clk);
    #2 clear_n = 1'b0;
    #1;
    chk("arst_cnt",   32'(count), 32'd0);
    chk("arst_dout",  32'(data_out), 32'd0);
    chk("arst_dv",    32'(data_out_valid), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_full",  32'(full), 32'd0);
    model_reset();
    @(negedge clk);
    clear_n = 1'b1;
    step(1'b0, 1'b1, 1'b0, 8'h55);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("post_rst_data", 32'(data_out), 32'h55);
    chk("post_rst_dv",   32'(data_out_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 16, number of storage words (power of 2, >=2).
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, almost_full threshold (1..DEPTH).
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, almost_empty threshold (0..DEPTH-1).
REQ-005 The block SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-006 The block SHALL have port clear_n  in  1  asynchronous active-low reset.
REQ-007 The block SHALL have port flush  in  1  synchronous empty request.
REQ-008 The block SHALL have port wr  in  1  write request.
REQ-009 The block SHALL have port data_in  in  WIDTH  write data.
REQ-010 The block SHALL have port rd  in  1  read request.
REQ-011 The block SHALL have port data_out  out  WIDTH  registered read data.
REQ-012 The block SHALL have port data_out_valid  out  1  data_out holds a word read on the previous edge.
REQ-013 The block SHALL have ports empty, full, almost_full, almost_empty  out  1 each  level flags.
REQ-014 The block SHALL have port count  out  $clog2(DEPTH)+1  words stored.
REQ-015 The block SHALL have ports overflow, underflow  out  1 each  sticky error flags.

Function
REQ-016 Flags SHALL be combinational from count: empty = (count==0); full = (count==DEPTH); almost_full = (count>=AF_LEVEL); almost_empty = (count<=AE_LEVEL).
REQ-017 A read SHALL be accepted iff rd=1 and empty=0 before the edge.
REQ-018 A write SHALL be accepted iff wr=1 and (full=0, or full=1 with a read accepted on the same edge).
REQ-019 Accepted write: mem[wr_ptr] <= data_in; wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
REQ-020 Accepted read: data_out <= mem[rd_ptr] and data_out_valid <= 1 on that edge (1-cycle latency); rd_ptr increments modulo DEPTH.
REQ-021 Edges with no accepted read SHALL set data_out_valid <= 0; data_out holds its previous value.
REQ-022 count: +1 write only; -1 read only; unchanged when both or neither accepted.
REQ-023 Empty with wr=1, rd=1: write accepted, read ignored, count 0 -> 1, data_out_valid <= 0, underflow set.
REQ-024 Full with wr=1, rd=1: both accepted, count stays DEPTH, oldest word output.
REQ-025 rd=1 while empty SHALL set underflow; wr=1 while full without accepted read SHALL set overflow; the data word is dropped and no other state changes.
REQ-026 overflow/underflow SHALL remain 1 until flush or reset.
REQ-027 flush=1 SHALL take priority over wr/rd on that edge: pointers and count <= 0, data_out_valid <= 0, overflow/underflow <= 0; data_out holds; wr/rd ignored.
REQ-028 Memory contents SHALL never be read past count; stale words are not observable.

Reset
REQ-029 clear_n=0 SHALL immediately, independent of clk, force wr_ptr, rd_ptr, count, data_out, data_out_valid, overflow, underflow to 0; hence empty=1, full=0, almost_empty=1, almost_full=0.
REQ-030 Reset mid-operation SHALL discard all stored words; memory array is not cleared.
REQ-031 Deassertion of clear_n SHALL be sampled so the first accepted operation occurs on the first rising edge with clear_n=1.

Verification (WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-032 After reset, wr=1, rd=1, data_in=0x01 on one edge -> count=1, data_out_valid=0, underflow=1, empty=0; next edge rd only -> data_out=0x01, data_out_valid=1, count=0.
REQ-033 Write 0x10,0x11,0x12,0x13 -> almost_full=1 at count 3, full=1 at count 4; fifth write 0x14 -> overflow=1, count=4; read four -> 0x10..0x13 in order, data_out_valid=1 each cycle.
REQ-034 Full, then wr=1/rd=1 with 0x20 -> data_out=0x10, count=4; drain -> 0x11,0x12,0x13,0x20 (pointer wrap checked).
REQ-035 Count=2 with overflow=1, assert flush with wr=1, rd=1 -> count=0, empty=1, overflow=0, data_out_valid=0, data_out unchanged.
REQ-036 Count=3, assert clear_n=0 between edges -> count, data_out, data_out_valid=0 and empty=1 without a clock edge; release, write 0x55, read -> data_out=0x55.
